// File: rtl/act_pkg.sv
// Shared constants for the activation stage: FSM encodings and datapath defaults
// common to the conv, pool and activation blocks.
package act_pkg;

  localparam int unsigned ActResult = 10;
  localparam int unsigned ActDepth  = 64;
  localparam int unsigned ActAddrW  = 6;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd   = 3'd1;
  localparam logic [2:0] StCap  = 3'd2;
  localparam logic [2:0] StWr   = 3'd3;
  localparam logic [2:0] StFin  = 3'd4;

endpackage

// File: rtl/relu_unit.sv
// Combinational signed ReLU clamp: negative inputs become zero, others pass through.
module relu_unit
  import act_pkg::*;
#(
  parameter int unsigned RESULT = ActResult
) (
  input  logic signed [RESULT-1:0] data_i,
  output logic signed [RESULT-1:0] data_o
);

  always_comb begin
    data_o = data_i[RESULT-1] ? '0 : data_i;
  end

endmodule

// File: rtl/act_sequencer.sv
// Walks the conv-result buffer, applies ReLU and writes the activation buffer, then pulses done.
// Optional negative-input counter (neg_cnt_o) is enabled by defining ACT_NEGCNT_EN.
module act_sequencer
  import act_pkg::*;
#(
  parameter int unsigned RESULT = ActResult,
  parameter int unsigned DEPTH  = ActDepth,
  parameter int unsigned ADDR_W = ActAddrW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     rd_en_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  input  logic signed [RESULT-1:0] rd_data_i,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic signed [RESULT-1:0] wr_data_o,
  input  logic                     wr_ready_i
`ifdef ACT_NEGCNT_EN
  ,
  output logic [ADDR_W:0]          neg_cnt_o
`endif
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  logic [2:0]               state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic signed [RESULT-1:0] wr_data_q, wr_data_d;
  logic signed [RESULT-1:0] relu_out;
`ifdef ACT_NEGCNT_EN
  logic [ADDR_W:0]          neg_cnt_q, neg_cnt_d;
`endif

  relu_unit #(
    .RESULT(RESULT)
  ) u_relu (
    .data_i(rd_data_i),
    .data_o(relu_out)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef ACT_NEGCNT_EN
    neg_cnt_d = neg_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRd;
          idx_d   = '0;
`ifdef ACT_NEGCNT_EN
          neg_cnt_d = '0;
`endif
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        // Source word is valid this cycle, one cycle after the read strobe.
        wr_data_d = relu_out;
        wr_addr_d = idx_q;
        state_d   = StWr;
`ifdef ACT_NEGCNT_EN
        if (rd_data_i[RESULT-1]) neg_cnt_d = neg_cnt_q + (ADDR_W + 1)'(1);
`endif
      end
      StWr: begin
        if (wr_ready_i) begin
          if (idx_q == LastIdx) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = StRd;
          end
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef ACT_NEGCNT_EN
      neg_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef ACT_NEGCNT_EN
      neg_cnt_q <= neg_cnt_d;
`endif
    end
  end

  assign busy_o    = (state_q == StRd) || (state_q == StCap) || (state_q == StWr);
  assign done_o    = (state_q == StFin);
  assign rd_en_o   = (state_q == StRd);
  assign rd_addr_o = idx_q;
  assign wr_en_o   = (state_q == StWr);
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
`ifdef ACT_NEGCNT_EN
  assign neg_cnt_o = neg_cnt_q;
`endif

endmodule

// File: tb/tb_act_sequencer.sv
// Directed self-checking bench for act_sequencer (DEPTH=4 main instance, DEPTH=1 corner instance).
module tb_act_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              start1 = 1'b0;
  logic              wr_ready = 1'b1;

  logic              busy, done, rd_en, wr_en;
  logic [5:0]        rd_addr, wr_addr;
  logic signed [9:0] rd_data, wr_data;
  logic              busy1, done1, rd_en1, wr_en1;
  logic [5:0]        rd_addr1, wr_addr1;
  logic signed [9:0] rd_data1, wr_data1;
`ifdef ACT_NEGCNT_EN
  logic [6:0]        neg_cnt, neg_cnt1;
`endif

  act_sequencer #(.RESULT(10), .DEPTH(4), .ADDR_W(6)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_ready_i(wr_ready)
`ifdef ACT_NEGCNT_EN
    , .neg_cnt_o(neg_cnt)
`endif
  );

  act_sequencer #(.RESULT(10), .DEPTH(1), .ADDR_W(6)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .rd_en_o(rd_en1), .rd_addr_o(rd_addr1), .rd_data_i(rd_data1),
    .wr_en_o(wr_en1), .wr_addr_o(wr_addr1), .wr_data_o(wr_data1), .wr_ready_i(wr_ready)
`ifdef ACT_NEGCNT_EN
    , .neg_cnt_o(neg_cnt1)
`endif
  );

  // Source RAM models: data returned one cycle after the read strobe.
  logic signed [9:0] src [4];
  logic signed [9:0] src1;
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= src[rd_addr[1:0]];
    if (rd_en1) rd_data1 <= src1;
  end

  int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
  int start1_cyc = 0, done1_cyc = 0, done1_cnt = 0, wr1_cnt = 0, wr1_last = 0;
  bit addr1_nonzero = 1'b0;
  int log_addr[$];
  int log_data[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy && !done) start_cyc <= cyc;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (wr_en && wr_ready) begin
      log_addr.push_back(int'(wr_addr));
      log_data.push_back(int'(wr_data));
    end
    if (start1 && !busy1 && !done1) start1_cyc <= cyc;
    if (done1) begin
      done1_cnt <= done1_cnt + 1;
      done1_cyc <= cyc;
    end
    if (wr_en1 && wr_ready) begin
      wr1_cnt  <= wr1_cnt + 1;
      wr1_last <= int'(wr_data1);
    end
    if (rd_addr1 != 6'd0 || wr_addr1 != 6'd0) addr1_nonzero <= 1'b1;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base_cnt, input string tag);
    int n;
    n = 0;
    while (done_cnt == base_cnt && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == base_cnt) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_writes(input string tag, input int base, input int e0, input int e1,
                              input int e2, input int e3);
    int exp_d[4];
    exp_d = '{e0, e1, e2, e3};
    check({tag, "_nwr"}, log_addr.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < log_addr.size()) begin
        check({tag, "_addr"}, log_addr[base+i], i);
        check({tag, "_data"}, log_data[base+i], exp_d[i]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
`ifdef ACT_NEGCNT_EN
    check({tag, "_neg_cnt"}, neg_cnt, 0);
`endif
  endtask

  initial begin
    int base, dc, n;
    bit found;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic run: writes {0,0,5,511}, done 13 cycles after start.
    src = '{-10'sd3, 10'sd0, 10'sd5, 10'sd511};
    base = log_addr.size();
    dc = done_cnt;
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_done(dc, "basic");
    check_writes("basic", base, 0, 0, 5, 511);
    check("basic_latency", done_cyc - start_cyc, 13);
    check("basic_busy_low", busy, 0);
    @(negedge clk);
    check("basic_done_single", done_cnt - dc, 1);

    // Boundary negatives, including the most-negative code.
    src = '{-10'sd1, -10'sd512, 10'sd7, -10'sd2};
    base = log_addr.size();
    dc = done_cnt;
    pulse_start();
    wait_done(dc, "neg");
    check_writes("neg", base, 0, 0, 7, 0);
`ifdef ACT_NEGCNT_EN
    check("neg_cnt", neg_cnt, 3);
    repeat (3) @(negedge clk);
    check("neg_cnt_hold", neg_cnt, 3);
`endif

    // Back-pressure: wr_ready low 5 cycles while element 1 is in WR.
    src = '{-10'sd4, 10'sd6, -10'sd8, 10'sd9};
    base = log_addr.size();
    dc = done_cnt;
    pulse_start();
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      if (wr_en && wr_addr == 6'd1) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("stall_found", found, 1);
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_wr_en", wr_en, 1);
      check("stall_wr_addr", wr_addr, 1);
      check("stall_wr_data", wr_data, 6);
      check("stall_no_rd", rd_en, 0);
    end
    wr_ready = 1'b1;
    wait_done(dc, "stall");
    check_writes("stall", base, 0, 6, 0, 9);
    check("stall_latency", done_cyc - start_cyc, 18);

    // Second start mid-run is ignored.
    src = '{10'sd1, 10'sd2, 10'sd3, 10'sd4};
    base = log_addr.size();
    dc = done_cnt;
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    wait_done(dc, "restart");
    repeat (20) @(negedge clk);
    check_writes("restart", base, 1, 2, 3, 4);
    check("restart_done_cnt", done_cnt - dc, 1);
    check("restart_idle", busy, 0);

    // Reset in WR of element 2 aborts; a fresh start begins at address 0.
    dc = done_cnt;
    pulse_start();
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      if (wr_en && wr_addr == 6'd2) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("abort_found", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_done", done_cnt - dc, 0);
    src = '{10'sd100, -10'sd100, 10'sd0, 10'sd200};
    base = log_addr.size();
    dc = done_cnt;
    pulse_start();
    wait_done(dc, "fresh");
    check_writes("fresh", base, 100, 0, 0, 200);

    // DEPTH=1 instance.
    src1 = 10'sd9;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (done1_cnt == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("d1_done_cnt", done1_cnt, 1);
    check("d1_latency", done1_cyc - start1_cyc, 4);
    check("d1_writes", wr1_cnt, 1);
    check("d1_data", wr1_last, 9);
    check("d1_addr_zero", addr1_nonzero, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
